gpio_pad_ctrl: RTL

Parametrised GPIO pad controller that sits between the SoC's `gpio_out`/`gpio_dir`/`gpio_in` and the FPGA top-level tristate buffers. It replaces the purely combinational per-pin direction mux with:
- registered output drive and output enables;
- multi-stage input synchronisation and an optional per-pin glitch filter;
- edge-event capture with a combined interrupt.

The top level builds `inout` pads from `pad_o`/`pad_oe_o`/`pad_i`.

---
 rtl/gpio_pad_pkg.sv | 13 +
 rtl/gpio_pad_in_filter.sv | 63 ++++++
 rtl/gpio_pad_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared constants and types for the GPIO pad controller.
package gpio_pad_pkg;
  localparam logic GPIO_DIR_IN  = 1'b0;
  localparam logic GPIO_DIR_OUT = 1'b1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_cfg_t;
endpackage

// File: rtl/gpio_pad_in_filter.sv
// One pin's input path: synchroniser, optional glitch filter (GPIO_PAD_FILTER_EN)
// and the previous-value register that yields rise/fall strobes.
module gpio_pad_in_filter
  import gpio_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pad,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_gpio_in,
  output logic              o_rise,
  output logic              o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;
  logic                   w_gin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_PAD_FILTER_EN
  logic              r_filt;
  logic [FILT_W-1:0] r_cnt;

  // >= rather than == so lowering the length mid-count releases on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt >= i_filt_len) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else if (r_cnt != '1) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign w_gin = r_filt;
`else
  logic w_unused_len;
  assign w_unused_len = ^i_filt_len;
  assign w_gin        = w_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_gin;
  end

  assign o_gpio_in = w_gin;
  assign o_rise    = w_gin & ~r_prev;
  assign o_fall    = ~w_gin & r_prev;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered output drive, per-pin input conditioning,
// edge-event flags and a combined interrupt. Filter enabled by GPIO_PAD_FILTER_EN.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NPADS       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPADS-1:0]  gpio_out,
  input  logic [NPADS-1:0]  gpio_dir,
  output logic [NPADS-1:0]  gpio_in,
  output logic [NPADS-1:0]  pad_o,
  output logic [NPADS-1:0]  pad_oe_o,
  input  logic [NPADS-1:0]  pad_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [NPADS-1:0]  rise_en_i,
  input  logic [NPADS-1:0]  fall_en_i,
  input  logic [NPADS-1:0]  evt_clr_i,
  output logic [NPADS-1:0]  evt_o,
  output logic              irq_o
);
  logic [NPADS-1:0]      r_pad_o;
  logic [NPADS-1:0]      r_pad_oe;
  logic [NPADS-1:0]      r_evt;
  logic                  r_irq;
  logic [NPADS-1:0]      w_gin;
  logic [NPADS-1:0]      w_rise;
  logic [NPADS-1:0]      w_fall;
  logic [NPADS-1:0]      w_set;
  edge_cfg_t [NPADS-1:0] w_cfg;

  // Value and enable share one edge so the pad never sees a mixed state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_o  <= '0;
      r_pad_oe <= {NPADS{GPIO_DIR_IN}};
    end else begin
      r_pad_o  <= gpio_out;
      r_pad_oe <= gpio_dir;
    end
  end

  for (genvar g = 0; g < NPADS; g++) begin : g_pin
    gpio_pad_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_in (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pad      (pad_i[g]),
      .i_filt_len (filt_len_i),
      .o_gpio_in  (w_gin[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g])
    );
    assign w_cfg[g] = '{rise: rise_en_i[g], fall: fall_en_i[g]};
    assign w_set[g] = (w_rise[g] & w_cfg[g].rise) | (w_fall[g] & w_cfg[g].fall);
  end

  // Set has priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_evt <= (r_evt & ~evt_clr_i) | w_set;
      r_irq <= |r_evt;
    end
  end

  assign pad_o    = r_pad_o;
  assign pad_oe_o = r_pad_oe;
  assign gpio_in  = w_gin;
  assign evt_o    = r_evt;
  assign irq_o    = r_irq;
endmodule
